mul_unit: RTL and testbench
===========================

Name: mul_unit

Overview:
- Iterative shift-add multiplier, directly downstream of the instruction decoder.
- Consumes ALUControl codes 3'b101 (MUL), 3'b110 (UMULL) and 3'b111 (SMULL), plus the two register operands.
- Produces a 64-bit product over WIDTH+2 cycles. While busy is high, mainfsm holds its multiply execute state; it advances when done is asserted.
- Replaces the single-cycle combinational multiply path in the ALU.

Parameters:
- WIDTH, 32, operand width in bits; the product is 2*WIDTH bits and the iteration count equals WIDTH.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request pulse, sampled only in IDLE.
- ALUControl  input  3  operation select from the decoder: 101 MUL, 110 UMULL, 111 SMULL.
- SrcA  input  WIDTH  multiplicand (Rn).
- SrcB  input  WIDTH  multiplier (Rm).
- busy  output  1  high in RUN and FIX.
- done  output  1  one-cycle pulse; results are valid from this cycle on.
- ResultLo  output  WIDTH  low half of the product.
- ResultHi  output  WIDTH  high half of the product for long ops; 0 for MUL.
- FlagN  output  1  negative flag of the result.
- FlagZ  output  1  zero flag of the result.

Behaviour:
- Reset: state = IDLE. busy, done, ResultLo, ResultHi, FlagN and FlagZ are all 0. The iteration counter and internal registers are cleared. Reset applied mid-operation aborts the operation at that edge; no done is produced.
- State IDLE:
  - On an edge with start=1 and ALUControl in {101,110,111}:
    - Latch the op code.
    - Latch operands as magnitudes. For SMULL each operand is replaced by its two's-complement absolute value and the sign of the result is recorded as sign = SrcA[MSB] ^ SrcB[MSB]. For MUL/UMULL, sign = 0.
    - Clear the 2*WIDTH-bit accumulator. Counter = 0. Go to RUN.
  - start with any other ALUControl is ignored: the unit stays in IDLE and outputs are unchanged.
- State RUN, one iteration per edge:
  - If multiplier bit 0 = 1, add the zero-extended multiplicand into the accumulator's upper WIDTH+1 bits.
  - Shift accumulator and multiplier right by 1.
  - Counter increments. After the WIDTH-th iteration (counter == WIDTH-1 at the edge), go to FIX.
- State FIX, single edge:
  - If sign = 1, the accumulator is two's-complement negated over 2*WIDTH bits.
  - Write the results:
    - ResultLo = acc[WIDTH-1:0].
    - ResultHi = acc[2*WIDTH-1:WIDTH] for UMULL/SMULL, 0 for MUL.
    - For MUL: FlagN = acc[WIDTH-1], FlagZ = (acc[WIDTH-1:0] == 0).
    - For long ops: FlagN = acc[2*WIDTH-1], FlagZ = (acc == 0).
  - Go to DONE.
- State DONE: done = 1 for exactly this cycle. The next edge returns to IDLE unconditionally. A start present in DONE is ignored.
- Latency: with start sampled at edge E0, done is high in the cycle following edge E(WIDTH+1), which is 34 cycles for WIDTH=32. busy is high from after E0 until after E(WIDTH+1).
- Results and flags hold their values from DONE until the next accepted start's FIX edge. They do not change during a subsequent RUN.
- start while busy: ignored, no queuing. Operand inputs are don't-care after E0.
- MUL low half is identical for signed and unsigned operands, so no sign handling is applied to MUL.
- SMULL with both operands = most-negative value: the magnitude 2^(WIDTH-1) fits in WIDTH unsigned bits and the product is positive.
- No overflow or carry outputs; C and V flag behaviour is owned by mainfsm/condlogic.

Test Plan:
- MUL, SrcA=7, SrcB=6 -> done at cycle 34: ResultLo=0x0000002A, ResultHi=0, N=0, Z=0. busy high for cycles 1-33 exactly.
- UMULL, 0xFFFFFFFF × 0xFFFFFFFF -> ResultHi=0xFFFFFFFE, ResultLo=0x00000001, N=1, Z=0.
- SMULL:
  - -2 (0xFFFFFFFE) × 3 -> ResultHi=0xFFFFFFFF, ResultLo=0xFFFFFFFA, N=1.
  - -1 × -1 -> Hi=0, Lo=1.
  - 0x80000000 × 0x80000000 -> Hi=0x40000000, Lo=0, N=0.
- Zero handling:
  - UMULL 0 × 0x12345678 -> Hi=Lo=0, Z=1.
  - MUL 0x00010000 × 0x00010000 -> Lo=0, Hi=0, Z=1.
- Pulse start=1 with new operands at cycle 10 of a run -> ignored; the original result is delivered at cycle 34 with a single done pulse.
- Assert reset at cycle 15 of a SMULL -> next cycle busy=0, all outputs 0, no done. A fresh MUL 3×5 then yields Lo=15.
- start with ALUControl=000 -> busy stays 0, no done, outputs unchanged.

Source files
------------

// File: rtl/mul_unit.sv
// mul_unit: iterative shift-add multiplier for MUL/UMULL/SMULL.
// One product bit per cycle; SMULL runs on magnitudes and negates in FIX.
module mul_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       ALUControl,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] ResultLo,
    output logic [WIDTH-1:0] ResultHi,
    output logic             FlagN,
    output logic             FlagZ
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [1:0]         r_state;
    logic [2:0]         r_op;
    logic               r_sign;
    logic [WIDTH-1:0]   r_mcand, r_mplier;
    logic [2*WIDTH-1:0] r_acc;
    logic [CW-1:0]      r_cnt;
    logic [WIDTH-1:0]   r_lo, r_hi;
    logic               r_n, r_z;

    logic               w_smull, w_go, w_long;
    logic [WIDTH-1:0]   w_abs_a, w_abs_b;
    logic [WIDTH:0]     w_sum;
    logic [2*WIDTH-1:0] w_fin;

    assign w_smull = ALUControl == 3'b111;
    assign w_go    = start && ALUControl[2] && (ALUControl[1:0] != 2'b00);
    // most-negative operand negates to itself, which is its correct unsigned magnitude
    assign w_abs_a = (w_smull && SrcA[WIDTH-1]) ? -SrcA : SrcA;
    assign w_abs_b = (w_smull && SrcB[WIDTH-1]) ? -SrcB : SrcB;
    assign w_sum   = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_mplier[0] ? {1'b0, r_mcand} : '0);
    assign w_fin   = r_sign ? -r_acc : r_acc;
    assign w_long  = r_op != 3'b101;

    assign busy     = (r_state == S_RUN) || (r_state == S_FIX);
    assign done     = r_state == S_DONE;
    assign ResultLo = r_lo;
    assign ResultHi = r_hi;
    assign FlagN    = r_n;
    assign FlagZ    = r_z;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_op     <= '0;
            r_sign   <= 1'b0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_lo     <= '0;
            r_hi     <= '0;
            r_n      <= 1'b0;
            r_z      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (w_go) begin
                    r_op     <= ALUControl;
                    r_mcand  <= w_abs_a;
                    r_mplier <= w_abs_b;
                    r_sign   <= w_smull && (SrcA[WIDTH-1] ^ SrcB[WIDTH-1]);
                    r_acc    <= '0;
                    r_cnt    <= '0;
                    r_state  <= S_RUN;
                end
                S_RUN: begin
                    r_acc    <= {w_sum, r_acc[WIDTH-1:1]};
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt + 1'b1;
                    r_state  <= (r_cnt == CW'(WIDTH - 1)) ? S_FIX : S_RUN;
                end
                S_FIX: begin
                    r_lo    <= w_fin[WIDTH-1:0];
                    r_hi    <= w_long ? w_fin[2*WIDTH-1:WIDTH] : '0;
                    r_n     <= w_long ? w_fin[2*WIDTH-1] : w_fin[WIDTH-1];
                    r_z     <= w_long ? (w_fin == '0) : (w_fin[WIDTH-1:0] == '0);
                    r_state <= S_DONE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mul_unit.sv
// tb_mul_unit: directed vectors for mul_unit with hand-computed products,
// latency/busy-window checks, start-while-busy, mid-run reset and illegal op.
module tb_mul_unit;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset, start;
    logic [2:0]   ALUControl;
    logic [W-1:0] SrcA, SrcB;
    logic         busy, done, FlagN, FlagZ;
    logic [W-1:0] ResultLo, ResultHi;

    int n_vec = 0;
    int n_err = 0;

    mul_unit #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start), .ALUControl(ALUControl),
        .SrcA(SrcA), .SrcB(SrcB), .busy(busy), .done(done),
        .ResultLo(ResultLo), .ResultHi(ResultHi), .FlagN(FlagN), .FlagZ(FlagZ)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input string tag, input logic [2:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input int inj, input logic [63:0] exp_prod,
                          input logic exp_n, input logic exp_z, input logic [W-1:0] prev_lo);
        int cnt, busy_cnt;
        ALUControl = op;
        SrcA = a;
        SrcB = b;
        start = 1'b1;
        tick();
        start = 1'b0;
        cnt = 1;
        busy_cnt = 0;
        while (!done && cnt < 100) begin
            busy_cnt += int'(busy);
            if (cnt == 10) check({tag, " hold"}, 64'(ResultLo), 64'(prev_lo));
            start = (cnt == inj);
            if (cnt == inj) begin
                ALUControl = 3'b111;
                SrcA = 32'hDEADBEEF;
                SrcB = 32'h0BADF00D;
            end
            tick();
            cnt++;
        end
        start = 1'b0;
        check({tag, " latency"}, 64'(cnt), 64'd34);
        check({tag, " busy cycles"}, 64'(busy_cnt), 64'd33);
        check({tag, " busy at done"}, 64'(busy), 64'd0);
        check({tag, " product"}, {ResultHi, ResultLo}, exp_prod);
        check({tag, " NZ"}, {62'd0, FlagN, FlagZ}, {62'd0, exp_n, exp_z});
        tick();
        check({tag, " done/busy after"}, {62'd0, done, busy}, 64'd0);
        check({tag, " product held"}, {ResultHi, ResultLo}, exp_prod);
    endtask

    initial begin
        int dones, busies;
        reset = 1'b1;
        start = 1'b0;
        ALUControl = 3'b000;
        SrcA = '0;
        SrcB = '0;
        tick();
        tick();
        check("reset outputs", {ResultHi, ResultLo}, 64'd0);
        check("reset ctrl", {60'd0, busy, done, FlagN, FlagZ}, 64'd0);
        reset = 1'b0;
        tick();

        run_op("mul 7x6",    3'b101, 32'd7,        32'd6,        -1, 64'h0000_0000_0000_002A, 1'b0, 1'b0, 32'h0);
        run_op("umull max",  3'b110, 32'hFFFFFFFF, 32'hFFFFFFFF, -1, 64'hFFFF_FFFE_0000_0001, 1'b1, 1'b0, 32'h2A);
        run_op("smull -2x3", 3'b111, 32'hFFFFFFFE, 32'd3,        -1, 64'hFFFF_FFFF_FFFF_FFFA, 1'b1, 1'b0, 32'h1);
        run_op("smull -1x-1",3'b111, 32'hFFFFFFFF, 32'hFFFFFFFF, -1, 64'h0000_0000_0000_0001, 1'b0, 1'b0, 32'hFFFFFFFA);
        run_op("smull minsq",3'b111, 32'h80000000, 32'h80000000, -1, 64'h4000_0000_0000_0000, 1'b0, 1'b0, 32'h1);
        run_op("umull zero", 3'b110, 32'd0,        32'h12345678, -1, 64'h0,                   1'b0, 1'b1, 32'h0);
        run_op("mul wrap",   3'b101, 32'h00010000, 32'h00010000, -1, 64'h0,                   1'b0, 1'b1, 32'h0);
        run_op("smull 5x-7", 3'b111, 32'd5,        32'hFFFFFFF9, -1, 64'hFFFF_FFFF_FFFF_FFDD, 1'b1, 1'b0, 32'h0);
        run_op("start busy", 3'b110, 32'h12345678, 32'h10,       10, 64'h0000_0001_2345_6780, 1'b0, 1'b0, 32'hFFFFFFDD);

        ALUControl = 3'b111;
        SrcA = 32'hFFFFFFFE;
        SrcB = 32'd3;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (14) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort ctrl", {60'd0, busy, done, FlagN, FlagZ}, 64'd0);
        check("abort outputs", {ResultHi, ResultLo}, 64'd0);
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            dones += int'(done);
            tick();
        end
        check("abort no done", 64'(dones), 64'd0);

        run_op("mul 3x5", 3'b101, 32'd3, 32'd5, -1, 64'h0000_0000_0000_000F, 1'b0, 1'b0, 32'h0);

        ALUControl = 3'b000;
        SrcA = 32'd9;
        SrcB = 32'd9;
        start = 1'b1;
        tick();
        start = 1'b0;
        dones = 0;
        busies = 0;
        for (int i = 0; i < 40; i++) begin
            dones += int'(done);
            busies += int'(busy);
            tick();
        end
        check("bad op busy", 64'(busies), 64'd0);
        check("bad op done", 64'(dones), 64'd0);
        check("bad op outputs", {ResultHi, ResultLo}, 64'h0000_0000_0000_000F);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
